// File: rtl/uart_dbg_pkg.sv
// uart_dbg_pkg: command/response codes, parser and receiver state encodings for uart_dbg_master
package uart_dbg_pkg;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;
    localparam int IDX_W = 2;
    typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_ISSUE, ST_RESP} dbg_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    function automatic logic is_cmd(input logic [7:0] b);
        return b == CMD_RD || b == CMD_WR;
    endfunction
endpackage

// File: rtl/uart_dbg_master_rx.sv
// uart_byte_rx: 8N1 receiver with 2-FF synchroniser, glitch-rejecting start check and stop-bit validation
module uart_byte_rx
    import uart_dbg_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] data,
    output logic       stop_err
);
    localparam int CW = $clog2(CLK_DIV);
    rx_state_t st;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] sh;
    logic s1, s2, s3;
    // synchronise rx, find the start edge, then sample each bit at its centre
    always_ff @(posedge clk) begin
        if (rst) begin
            {s3, s2, s1} <= 3'b111;
            st <= RX_IDLE;
            cnt <= '0;
            bit_idx <= '0;
            sh <= '0;
            data <= '0;
            byte_valid <= 1'b0;
            stop_err <= 1'b0;
        end else begin
            {s3, s2, s1} <= {s2, s1, rx};
            byte_valid <= 1'b0;
            stop_err <= 1'b0;
            cnt <= cnt + 1'b1;
            case (st)
                RX_IDLE: begin
                    cnt <= '0;
                    if (s3 && !s2) st <= RX_START;
                end
                RX_START: if (cnt == CW'(CLK_DIV / 2 - 1)) begin
                    cnt <= '0;
                    bit_idx <= '0;
                    st <= s2 ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (cnt == CW'(CLK_DIV - 1)) begin
                    cnt <= '0;
                    sh <= {s2, sh[7:1]};
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == 3'd7) st <= RX_STOP;
                end
                RX_STOP: if (cnt == CW'(CLK_DIV - 1)) begin
                    st <= RX_IDLE;
                    byte_valid <= s2;
                    stop_err <= !s2;
                    data <= sh;
                end
                default: st <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_dbg_master.sv
// uart_dbg_master: UART command frames to single XT_BUS reads/writes; optional UART_DBG_TIMEOUT_EN adds an inter-byte timeout
module uart_dbg_master
    import uart_dbg_pkg::*;
#(
    parameter int CLK_DIV      = 16,
    parameter int ADDR_W       = 32,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic              hb_clk,
    input  logic              hb_rst,
    input  logic              uart_rx,
    output logic              uart_tx,
    output logic              m_ren,
    output logic [ADDR_W-1:0] m_raddr,
    output logic              m_wen,
    output logic [ADDR_W-1:0] m_waddr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    output logic              busy,
    output logic              frame_err
);
    localparam int CW = $clog2(CLK_DIV);
    dbg_state_t state;
    logic is_wr;
    logic [IDX_W-1:0] idx;
    logic [31:0] addr, wdata, rbuf;
    logic [2:0] nb;
    logic [8:0] sh;
    logic [3:0] bits;
    logic [CW-1:0] div;
    logic tick, byte_valid, stop_err;
    logic [7:0] rx_data;
`ifdef UART_DBG_TIMEOUT_EN
    localparam int TMO_CYC = TIMEOUT_BITS * CLK_DIV;
    localparam int TW = $clog2(TMO_CYC);
    logic [TW-1:0] tmo;
`endif

    uart_byte_rx #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk(hb_clk),
        .rst(hb_rst),
        .rx(uart_rx),
        .byte_valid(byte_valid),
        .data(rx_data),
        .stop_err(stop_err)
    );

    assign tick = div == CW'(CLK_DIV - 1);
    assign m_raddr = addr[ADDR_W-1:0];
    assign m_waddr = addr[ADDR_W-1:0];
    assign m_wdata = wdata;

    // free-running baud divider for the transmitter
    always_ff @(posedge hb_clk) begin
        if (hb_rst) div <= '0;
        else div <= tick ? '0 : div + 1'b1;
    end

    // command parser, bus strobes and response shifter
    always_ff @(posedge hb_clk) begin
        if (hb_rst) begin
            state <= ST_IDLE;
            is_wr <= 1'b0;
            idx <= '0;
            addr <= '0;
            wdata <= '0;
            rbuf <= '0;
            nb <= '0;
            sh <= '0;
            bits <= '0;
            uart_tx <= 1'b1;
            m_ren <= 1'b0;
            m_wen <= 1'b0;
            busy <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_DBG_TIMEOUT_EN
            tmo <= '0;
`endif
        end else begin
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (stop_err) frame_err <= 1'b1;
                    else if (byte_valid) begin
                        busy <= 1'b1;
                        idx <= '0;
                        is_wr <= rx_data == CMD_WR;
                        if (is_cmd(rx_data)) state <= ST_ADDR;
                        else begin
                            // the error reply goes through RESP so input is ignored while it drains
                            frame_err <= 1'b1;
                            rbuf <= {24'd0, RSP_ERR};
                            nb <= 3'd1;
                            state <= ST_RESP;
                        end
                    end
                end
                ST_ADDR, ST_DATA: begin
                    if (stop_err) begin
                        frame_err <= 1'b1;
                        busy <= 1'b0;
                        state <= ST_IDLE;
                    end else if (byte_valid) begin
                        idx <= idx + 1'b1;
                        if (state == ST_ADDR) addr <= {rx_data, addr[31:8]};
                        else wdata <= {rx_data, wdata[31:8]};
                        if (&idx) begin
                            state <= (state == ST_ADDR && is_wr) ? ST_DATA : ST_ISSUE;
                            m_ren <= state == ST_ADDR && !is_wr;
                            m_wen <= state == ST_DATA;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (is_wr) begin
                        m_wen <= 1'b0;
                        rbuf <= {24'd0, RSP_ACK};
                        nb <= 3'd1;
                        state <= ST_RESP;
                    end else if (m_ren) m_ren <= 1'b0;
                    else begin
                        rbuf <= m_rdata;
                        nb <= 3'd4;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: if (tick) begin
                    if (bits != 4'd0) begin
                        uart_tx <= sh[0];
                        sh <= {1'b1, sh[8:1]};
                        bits <= bits - 1'b1;
                    end else if (nb != 3'd0) begin
                        uart_tx <= 1'b0;
                        sh <= {1'b1, rbuf[7:0]};
                        rbuf <= rbuf >> 8;
                        nb <= nb - 1'b1;
                        bits <= 4'd9;
                    end else begin
                        busy <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
`ifdef UART_DBG_TIMEOUT_EN
            // abandon a partial frame when the host goes quiet between bytes
            if ((state == ST_ADDR || state == ST_DATA) && !byte_valid && !stop_err) begin
                if (tmo == TW'(TMO_CYC - 1)) begin
                    tmo <= '0;
                    frame_err <= 1'b1;
                    busy <= 1'b0;
                    state <= ST_IDLE;
                end else tmo <= tmo + 1'b1;
            end else tmo <= '0;
`endif
        end
    end
endmodule

// File: tb/tb_uart_dbg_master.sv
// tb_uart_dbg_master: scoreboard bench; expected bus strobes and reply bytes are queued per frame, monitors pop and compare
module tb_uart_dbg_master;
    localparam int CLK_DIV = 16;
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;

    logic hb_clk, hb_rst, uart_rx, uart_tx, m_ren, m_wen, busy, frame_err;
    logic [31:0] m_raddr, m_waddr, m_wdata, m_rdata, rd_val;
    logic rd_d;
    int checks = 0, passed = 0, err_cnt = 0, exp_err = 0;
    bus_t bus_q[$];
    logic [7:0] tx_q[$];

    uart_dbg_master #(.CLK_DIV(CLK_DIV), .ADDR_W(32), .TIMEOUT_BITS(64)) dut (
        .hb_clk(hb_clk),
        .hb_rst(hb_rst),
        .uart_rx(uart_rx),
        .uart_tx(uart_tx),
        .m_ren(m_ren),
        .m_raddr(m_raddr),
        .m_wen(m_wen),
        .m_waddr(m_waddr),
        .m_wdata(m_wdata),
        .m_rdata(m_rdata),
        .busy(busy),
        .frame_err(frame_err)
    );

    initial begin
        hb_clk = 1'b0;
        forever #5 hb_clk = ~hb_clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    // read data is only valid in the cycle right after m_ren
    always @(posedge hb_clk) rd_d <= m_ren;
    assign m_rdata = rd_d ? rd_val : ~rd_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // bus monitor
    always @(negedge hb_clk) begin
        if (!hb_rst && (m_ren || m_wen)) begin
            if (bus_q.size() == 0) begin
                checks++;
                $display("FAIL bus_unexpected: got ren=%0b wen=%0b expected no strobe", m_ren, m_wen);
            end else begin
                bus_t e;
                e = bus_q.pop_front();
                chk("bus_kind", {31'd0, m_wen}, {31'd0, e.wr});
                chk("bus_ren", {31'd0, m_ren}, {31'd0, !e.wr});
                chk("bus_addr", e.wr ? m_waddr : m_raddr, e.addr);
                if (e.wr) chk("bus_wdata", m_wdata, e.data);
            end
        end
    end

    always @(negedge hb_clk) if (!hb_rst && frame_err) err_cnt++;

    // serial monitor: decode bytes on uart_tx at bit centres
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge hb_clk);
            if (!hb_rst && uart_tx === 1'b0) begin
                repeat (CLK_DIV / 2 - 1) @(negedge hb_clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge hb_clk);
                    b[i] = uart_tx;
                end
                repeat (CLK_DIV) @(negedge hb_clk);
                chk("tx_stop", {31'd0, uart_tx}, 32'd1);
                if (tx_q.size() == 0) begin
                    checks++;
                    $display("FAIL tx_unexpected: got byte %h expected none", b);
                end else chk("tx_byte", {24'd0, b}, {24'd0, tx_q.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CLK_DIV) @(negedge hb_clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CLK_DIV) @(negedge hb_clk);
        end
        uart_rx = stop;
        repeat (CLK_DIV) @(negedge hb_clk);
        uart_rx = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 20000) begin
            @(negedge hb_clk);
            n++;
        end
        checks++;
        if (busy) $display("FAIL %s_idle: got busy=1 expected busy=0", tag);
        else passed++;
        repeat (2 * CLK_DIV) @(negedge hb_clk);
    endtask

    // reference model: decide bus effect and reply from the command, then send the frame
    task automatic run_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] rdv);
        logic [7:0] f[$];
        f.push_back(cmd);
        if (cmd == 8'h52 || cmd == 8'h57) for (int i = 0; i < 4; i++) f.push_back(a[8*i+:8]);
        if (cmd == 8'h57) for (int i = 0; i < 4; i++) f.push_back(d[8*i+:8]);
        if (cmd == 8'h52) begin
            rd_val = rdv;
            bus_q.push_back('{1'b0, a, 32'd0});
            for (int i = 0; i < 4; i++) tx_q.push_back(rdv[8*i+:8]);
        end else if (cmd == 8'h57) begin
            bus_q.push_back('{1'b1, a, d});
            tx_q.push_back(8'h4B);
        end else begin
            tx_q.push_back(8'h45);
            exp_err++;
        end
        foreach (f[i]) send_byte(f[i], 1'b1);
        chk("busy_during_reply", {31'd0, busy}, 32'd1);
        wait_idle("frame");
        chk("frame_err_count", err_cnt, exp_err);
        chk("tx_queue_drained", tx_q.size(), 0);
        chk("bus_queue_drained", bus_q.size(), 0);
    endtask

    initial begin
        logic [7:0] c;
        hb_rst = 1'b1;
        uart_rx = 1'b1;
        rd_val = 32'h0;
        repeat (4) @(negedge hb_clk);
        chk("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_m_ren", {31'd0, m_ren}, 32'd0);
        chk("rst_m_wen", {31'd0, m_wen}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_m_raddr", m_raddr, 32'd0);
        chk("rst_m_waddr", m_waddr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        hb_rst = 1'b0;
        repeat (2 * CLK_DIV) @(negedge hb_clk);

        run_frame(8'h52, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF);
        run_frame(8'h57, 32'h0000_0004, 32'h1234_5678, 32'h0);
        run_frame(8'h33, 32'h0, 32'h0, 32'h0);

        // bad stop bit on the second address byte
        send_byte(8'h52, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h10, 1'b0);
        exp_err++;
        repeat (4) @(negedge hb_clk);
        chk("badstop_err", err_cnt, exp_err);
        chk("badstop_busy", {31'd0, busy}, 32'd0);
        repeat (CLK_DIV) @(negedge hb_clk);
        run_frame(8'h52, 32'hA5A5_0F0F, 32'h0, 32'h0BAD_CAFE);

        // quarter-bit glitch must not start a byte
        uart_rx = 1'b0;
        repeat (CLK_DIV / 4) @(negedge hb_clk);
        uart_rx = 1'b1;
        repeat (3 * CLK_DIV) @(negedge hb_clk);
        chk("glitch_err", err_cnt, exp_err);
        chk("glitch_busy", {31'd0, busy}, 32'd0);
        run_frame(8'h52, 32'h0000_0020, 32'h0, 32'h1357_9BDF);

        // reset in the middle of the data bytes abandons the write
        send_byte(8'h57, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'h11 * i[7:0], 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        hb_rst = 1'b1;
        repeat (3) @(negedge hb_clk);
        hb_rst = 1'b0;
        @(negedge hb_clk);
        chk("midrst_uart_tx", {31'd0, uart_tx}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_m_wen", {31'd0, m_wen}, 32'd0);
        repeat (20 * CLK_DIV) @(negedge hb_clk);
        chk("midrst_err", err_cnt, exp_err);

`ifdef UART_DBG_TIMEOUT_EN
        send_byte(8'h57, 1'b1);
        send_byte(8'h01, 1'b1);
        exp_err++;
        repeat (65 * CLK_DIV) @(negedge hb_clk);
        chk("timeout_err", err_cnt, exp_err);
        chk("timeout_busy", {31'd0, busy}, 32'd0);
        repeat (20 * CLK_DIV) @(negedge hb_clk);
        chk("timeout_no_reply", tx_q.size(), 0);
        run_frame(8'h52, 32'h0000_0040, 32'h0, 32'h2468_ACE0);
`endif

        for (int n = 0; n < 14; n++) begin
            int r;
            r = $urandom_range(0, 9);
            c = $urandom_range(0, 255);
            if (c == 8'h52 || c == 8'h57) c = 8'h33;
            if (r < 4) run_frame(8'h52, $urandom, 32'h0, $urandom);
            else if (r < 8) run_frame(8'h57, $urandom, $urandom, 32'h0);
            else run_frame(c, 32'h0, 32'h0, 32'h0);
        end

        chk("end_bus_queue", bus_q.size(), 0);
        chk("end_tx_queue", tx_q.size(), 0);
        chk("end_err", err_cnt, exp_err);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
